// File: rtl/alu_pkg.sv
// Widths shared by the 8-bit ALU and its downstream stages, so both sides
// agree on the result and opcode sizes.
package alu_pkg;
  localparam int RESULT_W = 16;
  localparam int OPCODE_W = 3;

  typedef logic [RESULT_W-1:0] result_t;
endpackage

// File: rtl/alu_result_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port; contents are intentionally not reset.
module alu_result_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_buffer.sv
// FWFT result FIFO behind the ALU: captures opVld-qualified results, serves a
// valid/ready consumer, reports occupancy and a sticky overflow.
// Optional running sum of pushed results: define ALU_RESULT_SUM_EN.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = RESULT_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow
`ifdef ALU_RESULT_SUM_EN
  ,
  output logic [DATA_W+7:0] sum_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign dout_vld = !empty;
  assign dout     = empty ? '0 : rdata;
  assign pop      = dout_vld && dout_rdy;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push     = res_vld && (!full || pop);

  alu_result_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (res_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (res_vld && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef ALU_RESULT_SUM_EN
  always_ff @(posedge clk) begin
    if (reset)     sum_out <= '0;
    else if (push) sum_out <= sum_out + {8'h00, res_in};
  end
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (DEPTH = 8, DATA_W = 16).
// Also exercises sum_out when built with ALU_RESULT_SUM_EN.
module tb_alu_result_buffer;
  logic        clk;
  logic        reset;
  logic [15:0] res_in;
  logic        res_vld;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef ALU_RESULT_SUM_EN
  logic [23:0] sum_out;
`endif

  int tests = 0;
  int fails = 0;

  alu_result_buffer #(.DEPTH(8), .DATA_W(16), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .res_in   (res_in),
    .res_vld  (res_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef ALU_RESULT_SUM_EN
    ,
    .sum_out  (sum_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0001;
    exp_seq[1] = 16'h00FF;
    exp_seq[2] = 16'hFE01;

    reset = 1'b1; res_in = '0; res_vld = 1'b0; dout_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overflow", overflow, 0);

    // three pushes held back by the consumer, then drained
    for (int i = 0; i < 3; i++) begin
      res_in = exp_seq[i]; res_vld = 1'b1;
      tick();
    end
    res_vld = 1'b0;
    chk("t1_count", count, 3);
    chk("t1_dout_vld", dout_vld, 1);
    chk("t1_head", dout, 16'h0001);
    tick();
    chk("t1_hold", dout, 16'h0001);
    dout_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_drain", dout, exp_seq[i]);
      tick();
    end
    dout_rdy = 1'b0;
    chk("t1_empty", empty, 1);
    chk("t1_dout_zero", dout, 0);

    // overfill by one: 0x0018 is dropped
    for (int i = 0; i < 9; i++) begin
      res_in = 16'h0010 + 16'(i); res_vld = 1'b1;
      tick();
      if (i == 7) begin
        chk("t2_full8", full, 1);
        chk("t2_count8", count, 8);
        chk("t2_no_ovf_yet", overflow, 0);
      end
    end
    res_vld = 1'b0;
    chk("t2_overflow", overflow, 1);
    chk("t2_count_after_drop", count, 8);
    dout_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", dout, 16'h0010 + 16'(i));
      tick();
    end
    dout_rdy = 1'b0;
    chk("t2_empty", empty, 1);
    chk("t2_ovf_sticky", overflow, 1);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);

    // full with simultaneous push and pop: nothing dropped
    for (int i = 0; i < 8; i++) begin
      res_in = 16'h0020 + 16'(i); res_vld = 1'b1;
      tick();
    end
    chk("t3_full", full, 1);
    res_in = 16'hABCD; res_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    res_vld = 1'b0;
    chk("t3_count", count, 8);
    chk("t3_overflow", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      chk("t3_drain", dout, 16'h0020 + 16'(i));
      tick();
    end
    chk("t3_last", dout, 16'hABCD);
    tick();
    dout_rdy = 1'b0;
    chk("t3_empty", empty, 1);

    // push and pop together at count == 1
    res_in = 16'h1111; res_vld = 1'b1;
    tick();
    chk("t4_head", dout, 16'h1111);
    res_in = 16'h2222; dout_rdy = 1'b1;
    tick();
    res_vld = 1'b0; dout_rdy = 1'b0;
    chk("t4_new_head", dout, 16'h2222);
    chk("t4_count", count, 1);
    chk("t4_vld", dout_vld, 1);
    dout_rdy = 1'b1; tick(); dout_rdy = 1'b0;
    chk("t4_empty", empty, 1);

    // streaming through pointer wrap
    dout_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk("t5_order", dout, 16'h3000 + 16'(i - 1));
      res_in = 16'h3000 + 16'(i); res_vld = 1'b1;
      tick();
      chk("t5_count", count, 1);
    end
    res_vld = 1'b0;
    chk("t5_last", dout, 16'h3013);
    tick();
    dout_rdy = 1'b0;
    chk("t5_empty", empty, 1);

    // reset mid-stream with five entries; res_vld during reset is ignored
    for (int i = 0; i < 5; i++) begin
      res_in = 16'h4000 + 16'(i); res_vld = 1'b1;
      tick();
    end
    chk("t6_count5", count, 5);
    reset = 1'b1; dout_rdy = 1'b1;
    tick();
    chk("t6_count", count, 0);
    chk("t6_vld", dout_vld, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_dout", dout, 0);
    tick();
    chk("t6_ignore_vld", count, 0);
    res_vld = 1'b0; dout_rdy = 1'b0; reset = 1'b0;
    tick();
    chk("t6_still_empty", empty, 1);

`ifdef ALU_RESULT_SUM_EN
    chk("sum_reset", sum_out, 0);
    for (int i = 0; i < 3; i++) begin
      res_in = 16'hFFFF; res_vld = 1'b1;
      tick();
    end
    chk("sum_3xffff", sum_out, 24'h02FFFD);
    for (int i = 0; i < 5; i++) begin
      res_in = 16'h0001; res_vld = 1'b1;
      tick();
    end
    chk("sum_full", sum_out, 24'h030002);
    chk("sum_is_full", full, 1);
    res_in = 16'h7777; res_vld = 1'b1;
    tick();
    res_vld = 1'b0;
    chk("sum_drop", sum_out, 24'h030002);
    chk("sum_drop_ovf", overflow, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
